// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: decoded control bundle layout and register-file
// geometry used by the decode/execute boundary and later stages.
package pipe_pkg;

  localparam int unsigned REG_AW = 4;
  localparam int unsigned CTRL_W = 11;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       mode_sel;
    logic       reg_write_v;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch_flag;
    logic       imm_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an incoming instruction that reads the
// destination of a load still sitting in the downstream slot.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              held_valid,
  input  logic [CTRL_W-1:0] held_ctrl,
  input  logic [ADDR_W-1:0] held_rd,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  output logic              stall
);

  ctrl_t held;
  ctrl_t incoming;
  logic  reads_rd;
  logic  class_hit;

  always_comb begin
    held     = ctrl_t'(held_ctrl);
    incoming = ctrl_t'(in_ctrl);
    reads_rd = (in_rs1 == held_rd) || ((in_rs2 == held_rd) && !incoming.imm_src);
    // Scalar r0 is hardwired zero; the vector file has a real register 0.
    if (incoming.mode_sel) begin
      class_hit = held.reg_write_v;
    end else begin
      class_hit = held.reg_write && (held_rd != '0);
    end
    stall = held_valid && held.mem_to_reg && in_valid && reads_rd && class_hit;
  end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode-to-execute pipeline slot with valid/ready handshake, load-use bubble
// insertion, branch squash and saturating stall/bubble performance counters.
module decode_execute_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned VEC_W  = 256,
  parameter int unsigned REG_AW = pipe_pkg::REG_AW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic [CTRL_W-1:0] ctrlIn,
  input  logic [REG_AW-1:0] rs1In,
  input  logic [REG_AW-1:0] rs2In,
  input  logic [REG_AW-1:0] rdIn,
  input  logic [DATA_W-1:0] srcAIn,
  input  logic [DATA_W-1:0] srcBIn,
  input  logic [DATA_W-1:0] immIn,
  input  logic [VEC_W-1:0]  vecAIn,
  input  logic [VEC_W-1:0]  vecBIn,
  input  logic              flush,
  input  logic              outReady,
  output logic              outValid,
  output logic [CTRL_W-1:0] ctrlOut,
  output logic [REG_AW-1:0] rs1Out,
  output logic [REG_AW-1:0] rs2Out,
  output logic [REG_AW-1:0] rdOut,
  output logic [DATA_W-1:0] srcAOut,
  output logic [DATA_W-1:0] srcBOut,
  output logic [DATA_W-1:0] immOut,
  output logic [VEC_W-1:0]  vecAOut,
  output logic [VEC_W-1:0]  vecBOut,
  output logic              loadUseStall,
  output logic [CNT_W-1:0]  stallCnt,
  output logic [CNT_W-1:0]  bubbleCnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d, imm_q, imm_d;
  logic [VEC_W-1:0]  vec_a_q, vec_a_d, vec_b_q, vec_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic              load_use;
  logic              in_ready;

  load_use_detect #(
    .ADDR_W(REG_AW)
  ) u_load_use_detect (
    .held_valid(valid_q),
    .held_ctrl (ctrl_q),
    .held_rd   (rd_q),
    .in_valid  (inValid),
    .in_ctrl   (ctrlIn),
    .in_rs1    (rs1In),
    .in_rs2    (rs2In),
    .stall     (load_use)
  );

  always_comb begin
    in_ready = !load_use && (!valid_q || outReady);
  end

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    imm_d        = imm_q;
    vec_a_d      = vec_a_q;
    vec_b_d      = vec_b_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    // Flush drops a same-cycle transfer even though inReady reported acceptance.
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else if (valid_q && !outReady) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else if (inValid && in_ready) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_t'(ctrlIn);
      rs1_d   = rs1In;
      rs2_d   = rs2In;
      rd_d    = rdIn;
      src_a_d = srcAIn;
      src_b_d = srcBIn;
      imm_d   = immIn;
      vec_a_d = vecAIn;
      vec_b_d = vecBIn;
    end else begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      if (load_use && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      ctrl_q       <= CTRL_NOP;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      imm_q        <= '0;
      vec_a_q      <= '0;
      vec_b_q      <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      imm_q        <= imm_d;
      vec_a_q      <= vec_a_d;
      vec_b_q      <= vec_b_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  always_comb begin
    inReady      = in_ready;
    loadUseStall = load_use;
    outValid     = valid_q;
    ctrlOut      = ctrl_q;
    rs1Out       = rs1_q;
    rs2Out       = rs2_q;
    rdOut        = rd_q;
    srcAOut      = src_a_q;
    srcBOut      = src_b_q;
    immOut       = imm_q;
    vecAOut      = vec_a_q;
    vecBOut      = vec_b_q;
    stallCnt     = stall_cnt_q;
    bubbleCnt    = bubble_cnt_q;
  end

endmodule

// File: tb/tb_decode_execute_reg.sv
// Self-checking bench for decode_execute_reg: directed table of test-plan
// sequences, randomized traffic against a reference model, counter saturation.
module tb_decode_execute_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValid;
  logic         inReady;
  logic [10:0]  ctrlIn;
  logic [3:0]   rs1In, rs2In, rdIn;
  logic [31:0]  srcAIn, srcBIn, immIn;
  logic [255:0] vecAIn, vecBIn;
  logic         flush;
  logic         outReady;
  logic         outValid;
  logic [10:0]  ctrlOut;
  logic [3:0]   rs1Out, rs2Out, rdOut;
  logic [31:0]  srcAOut, srcBOut, immOut;
  logic [255:0] vecAOut, vecBOut;
  logic         loadUseStall;
  logic [15:0]  stallCnt, bubbleCnt;

  decode_execute_reg #(
    .DATA_W(32),
    .VEC_W (256),
    .REG_AW(4),
    .CNT_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inValid     (inValid),
    .inReady     (inReady),
    .ctrlIn      (ctrlIn),
    .rs1In       (rs1In),
    .rs2In       (rs2In),
    .rdIn        (rdIn),
    .srcAIn      (srcAIn),
    .srcBIn      (srcBIn),
    .immIn       (immIn),
    .vecAIn      (vecAIn),
    .vecBIn      (vecBIn),
    .flush       (flush),
    .outReady    (outReady),
    .outValid    (outValid),
    .ctrlOut     (ctrlOut),
    .rs1Out      (rs1Out),
    .rs2Out      (rs2Out),
    .rdOut       (rdOut),
    .srcAOut     (srcAOut),
    .srcBOut     (srcBOut),
    .immOut      (immOut),
    .vecAOut     (vecAOut),
    .vecBOut     (vecBOut),
    .loadUseStall(loadUseStall),
    .stallCnt    (stallCnt),
    .bubbleCnt   (bubbleCnt)
  );

  always #5 clk = ~clk;

  // Control encodings: [10:7] alu, [6] mode, [5] wrV, [4] wr, [3] memToReg, [2] memWr, [1] br, [0] imm
  localparam logic [10:0] ALU  = 11'h110;
  localparam logic [10:0] LD   = 11'h019;
  localparam logic [10:0] ADDI = 11'h111;
  localparam logic [10:0] VLD  = 11'h068;
  localparam logic [10:0] VADD = 11'h160;

  int total = 0;
  int bad   = 0;

  // Reference model of the slot contents
  bit           m_valid;
  logic [10:0]  m_ctrl;
  logic [3:0]   m_rs1, m_rs2, m_rd;
  logic [31:0]  m_a, m_b, m_imm;
  logic [255:0] m_va, m_vb;
  int           m_stallc, m_bubc;

  typedef struct {
    bit          rst, in_v, fl, ordy;
    logic [10:0] ctrl;
    logic [3:0]  rs1, rs2, rd;
    bit          e_valid;
    logic [10:0] e_ctrl;
    bit          e_stall, e_ready;
    int          e_stallc, e_bub;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rnd_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit model_hazard();
    bit reads, cls;
    if (!(m_valid && m_ctrl[3] && inValid)) return 1'b0;
    reads = (rs1In == m_rd) || ((rs2In == m_rd) && !ctrlIn[0]);
    if (ctrlIn[6]) cls = m_ctrl[5];
    else cls = m_ctrl[4] && (m_rd != 4'd0);
    return reads && cls;
  endfunction

  task automatic model_update(input bit hz, input bit rdy);
    if (rst) begin
      m_valid = 0; m_ctrl = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
      m_a = '0; m_b = '0; m_imm = '0; m_va = '0; m_vb = '0;
      m_stallc = 0; m_bubc = 0;
    end else if (flush) begin
      m_valid = 0; m_ctrl = '0;
    end else if (m_valid && !outReady) begin
      m_stallc = (m_stallc < 65535) ? m_stallc + 1 : 65535;
    end else if (inValid && rdy) begin
      m_valid = 1; m_ctrl = ctrlIn; m_rs1 = rs1In; m_rs2 = rs2In; m_rd = rdIn;
      m_a = srcAIn; m_b = srcBIn; m_imm = immIn; m_va = vecAIn; m_vb = vecBIn;
    end else begin
      m_valid = 0; m_ctrl = '0;
      if (hz) m_bubc = (m_bubc < 65535) ? m_bubc + 1 : 65535;
    end
  endtask

  task automatic check_model(input bit hz, input bit rdy);
    chk("outValid", 256'(outValid), 256'(m_valid));
    chk("ctrlOut", 256'(ctrlOut), 256'(m_ctrl));
    chk("loadUseStall", 256'(loadUseStall), 256'(hz));
    chk("inReady", 256'(inReady), 256'(rdy));
    chk("stallCnt", 256'(stallCnt), 256'(m_stallc));
    chk("bubbleCnt", 256'(bubbleCnt), 256'(m_bubc));
    if (m_valid) begin
      chk("rs1Out", 256'(rs1Out), 256'(m_rs1));
      chk("rs2Out", 256'(rs2Out), 256'(m_rs2));
      chk("rdOut", 256'(rdOut), 256'(m_rd));
      chk("srcAOut", 256'(srcAOut), 256'(m_a));
      chk("srcBOut", 256'(srcBOut), 256'(m_b));
      chk("immOut", 256'(immOut), 256'(m_imm));
      chk("vecAOut", vecAOut, m_va);
      chk("vecBOut", vecBOut, m_vb);
    end
  endtask

  // One clock: sample at negedge, advance model, drive next inputs 1 after posedge
  task automatic cycle(input bit do_chk, input bit use_row, input vec_t r);
    bit hz, rdy;
    @(negedge clk);
    hz  = model_hazard();
    rdy = !hz && (!m_valid || outReady);
    if (use_row) begin
      chk("tbl.outValid", 256'(outValid), 256'(r.e_valid));
      chk("tbl.ctrlOut", 256'(ctrlOut), 256'(r.e_ctrl));
      chk("tbl.loadUseStall", 256'(loadUseStall), 256'(r.e_stall));
      chk("tbl.inReady", 256'(inReady), 256'(r.e_ready));
      chk("tbl.stallCnt", 256'(stallCnt), 256'(r.e_stallc));
      chk("tbl.bubbleCnt", 256'(bubbleCnt), 256'(r.e_bub));
    end
    if (do_chk) check_model(hz, rdy);
    model_update(hz, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic row(input bit r_rst, input bit iv, input bit fl, input bit ordy,
                     input logic [10:0] c, input int a1, input int a2, input int d,
                     input bit ev, input logic [10:0] ec, input bit es, input bit er,
                     input int esc, input int eb);
    vec_t v;
    v.rst = r_rst; v.in_v = iv; v.fl = fl; v.ordy = ordy; v.ctrl = c;
    v.rs1 = 4'(a1); v.rs2 = 4'(a2); v.rd = 4'(d);
    v.e_valid = ev; v.e_ctrl = ec; v.e_stall = es; v.e_ready = er;
    v.e_stallc = esc; v.e_bub = eb;
    tbl.push_back(v);
  endtask

  task automatic drive_payload();
    srcAIn = $urandom; srcBIn = $urandom; immIn = $urandom;
    vecAIn = rnd_vec(); vecBIn = rnd_vec();
  endtask

  vec_t none;

  initial begin
    // rst iv fl ordy ctrl rs1 rs2 rd | valid ctrl stall ready stallc bub
    row(0,1,0,1, ALU , 1,2, 5,  0,11'h0,0,1, 0,0);
    row(0,1,0,1, ALU , 1,2, 6,  1,ALU  ,0,1, 0,0);
    row(0,1,0,1, ALU , 1,2, 7,  1,ALU  ,0,1, 0,0);
    row(0,1,0,1, ALU , 1,2, 8,  1,ALU  ,0,1, 0,0);
    row(0,0,0,1, 11'h0,0,0, 0,  1,ALU  ,0,1, 0,0);
    row(0,0,0,1, 11'h0,0,0, 0,  0,11'h0,0,1, 0,0);
    row(0,1,0,1, LD  , 1,2, 3,  0,11'h0,0,1, 0,0);
    row(0,1,0,1, ALU , 3,4, 9,  1,LD   ,1,0, 0,0);
    row(0,1,0,1, ALU , 3,4, 9,  0,11'h0,0,1, 0,1);
    row(0,0,0,1, 11'h0,0,0, 0,  1,ALU  ,0,1, 0,1);
    row(0,1,0,1, LD  , 1,2, 3,  0,11'h0,0,1, 0,1);
    row(0,1,0,1, ADDI, 1,3, 9,  1,LD   ,0,1, 0,1);
    row(0,1,0,1, LD  , 1,2, 0,  1,ADDI ,0,1, 0,1);
    row(0,1,0,1, ALU , 0,0, 2,  1,LD   ,0,1, 0,1);
    row(0,1,0,1, VLD , 1,2, 0,  1,ALU  ,0,1, 0,1);
    row(0,1,0,1, VADD, 0,5, 6,  1,VLD  ,1,0, 0,1);
    row(0,1,0,1, VADD, 0,5, 6,  0,11'h0,0,1, 0,2);
    row(0,1,0,0, ALU , 1,2,10,  1,VADD ,0,0, 0,2);
    row(0,1,0,0, ALU , 1,2,10,  1,VADD ,0,0, 1,2);
    row(0,1,0,0, ALU , 1,2,10,  1,VADD ,0,0, 2,2);
    row(0,1,0,1, ALU , 1,2,10,  1,VADD ,0,1, 3,2);
    row(0,1,1,1, ALU , 1,2,11,  1,ALU  ,0,1, 3,2);
    row(0,0,0,1, 11'h0,0,0, 0,  0,11'h0,0,1, 3,2);
    row(0,1,0,1, LD  , 1,2, 3,  0,11'h0,0,1, 3,2);
    row(0,1,1,1, ALU , 3,4, 9,  1,LD   ,1,0, 3,2);
    row(0,0,0,1, 11'h0,0,0, 0,  0,11'h0,0,1, 3,2);
    row(0,1,0,1, ALU , 1,2,12,  0,11'h0,0,1, 3,2);
    row(0,1,0,0, ALU , 1,2,13,  1,ALU  ,0,0, 3,2);
    row(1,1,0,0, ALU , 1,2,14,  1,ALU  ,0,0, 4,2);
    row(0,0,0,0, 11'h0,0,0, 0,  0,11'h0,0,1, 0,0);

    rst = 1; inValid = 0; ctrlIn = '0; rs1In = '0; rs2In = '0; rdIn = '0;
    flush = 0; outReady = 1; drive_payload();
    none = tbl[0];
    m_valid = 0; m_ctrl = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    m_a = '0; m_b = '0; m_imm = '0; m_va = '0; m_vb = '0; m_stallc = 0; m_bubc = 0;
    @(posedge clk); #1;
    cycle(0, 0, none);
    cycle(0, 0, none);
    rst = 0;

    foreach (tbl[i]) begin
      rst = tbl[i].rst; inValid = tbl[i].in_v; flush = tbl[i].fl; outReady = tbl[i].ordy;
      ctrlIn = tbl[i].ctrl; rs1In = tbl[i].rs1; rs2In = tbl[i].rs2; rdIn = tbl[i].rd;
      drive_payload();
      cycle(1, 1, tbl[i]);
    end

    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      inValid  = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      outReady = ($urandom_range(0, 3) != 0);
      ctrlIn   = 11'($urandom);
      rs1In    = 4'($urandom_range(0, 3));
      rs2In    = 4'($urandom_range(0, 3));
      rdIn     = 4'($urandom_range(0, 3));
      drive_payload();
      cycle(1, 0, none);
    end

    rst = 1; inValid = 0; flush = 0; outReady = 1; ctrlIn = '0;
    cycle(1, 0, none);
    rst = 0; inValid = 1; ctrlIn = ALU; rs1In = 4'd1; rs2In = 4'd2; rdIn = 4'd7;
    drive_payload();
    cycle(1, 0, none);
    inValid = 0; outReady = 0;
    for (int i = 0; i < 65540; i++) cycle(0, 0, none);
    @(negedge clk);
    chk("stallCnt.saturated", 256'(stallCnt), 256'(16'hFFFF));
    chk("outValid.held", 256'(outValid), 256'(1'b1));
    @(posedge clk); #1;
    cycle(1, 0, none);
    @(negedge clk);
    chk("stallCnt.no_wrap", 256'(stallCnt), 256'(16'hFFFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
